// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line-level bit constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Registered parity generator for the UART transmitter.
// It is loaded when a byte is accepted and holds its value for the whole frame.
module uart_tx_parity_calc #(
  parameter int OUT_data = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [OUT_data-1:0] i_data,
  input  logic                i_odd,
  output logic                o_parity
);

  logic r_parity;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_parity <= 1'b0;
    end else if (i_load) begin
      r_parity <= (^i_data) ^ i_odd;
    end
  end

  assign o_parity = r_parity;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, then stop.
// Define UART_TX_STOP2_EN to send two stop bits instead of one.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (low) for one bit time
// DATA   | data bit r_bit_cnt, one bit time each
// PARITY | parity bit for one bit time
// STOP   | stop bit(s), high
module uart_tx
  import uart_pkg::*;
#(
  parameter int OUT_data   = 8,
  parameter int prescale_w = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OUT_data-1:0]   P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [prescale_w-1:0] Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int BIT_W = (OUT_data > 1) ? $clog2(OUT_data) : 1;
`ifdef UART_TX_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(OUT_data - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  uart_state_e           r_state;
  logic [OUT_data-1:0]   r_data;
  logic                  r_par_en;
  logic [prescale_w-1:0] r_prescale;
  logic [prescale_w-1:0] r_presc_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_tx;
  logic                  r_busy;

  logic                  w_parity;
  logic                  w_load;
  logic [prescale_w-1:0] w_presc_last;
  logic                  w_bit_end;
  logic [BIT_W-1:0]      w_bit_next;

  assign w_load       = (r_state == IDLE) && Data_Valid;
  // A prescale of 0 behaves like 1: every cycle closes a bit.
  assign w_presc_last = (r_prescale == '0) ? '0 : r_prescale - 1'b1;
  assign w_bit_end    = (r_presc_cnt == w_presc_last);
  assign w_bit_next   = r_bit_cnt + 1'b1;

  uart_tx_parity_calc #(.OUT_data(OUT_data)) u_parity (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_load   (w_load),
    .i_data   (P_DATA),
    .i_odd    (PAR_TYP),
    .o_parity (w_parity)
  );

  // Line and busy are computed alongside the next state so both stay registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_par_en    <= 1'b0;
      r_prescale  <= '0;
      r_presc_cnt <= '0;
      r_bit_cnt   <= '0;
      r_tx        <= STOP_BIT;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx        <= STOP_BIT;
          r_busy      <= 1'b0;
          r_presc_cnt <= '0;
          r_bit_cnt   <= '0;
          if (Data_Valid) begin
            r_data     <= P_DATA;
            r_par_en   <= PAR_EN;
            r_prescale <= Prescale;
            r_tx       <= START_BIT;
            r_busy     <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_presc_cnt <= '0;
            r_bit_cnt   <= '0;
            r_tx        <= r_data[0];
            r_state     <= DATA;
          end else begin
            r_presc_cnt <= r_presc_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_presc_cnt <= '0;
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= '0;
              if (r_par_en) begin
                r_tx    <= w_parity;
                r_state <= PARITY;
              end else begin
                r_tx    <= STOP_BIT;
                r_state <= STOP;
              end
            end else begin
              r_bit_cnt <= w_bit_next;
              r_tx      <= r_data[w_bit_next];
            end
          end else begin
            r_presc_cnt <= r_presc_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_presc_cnt <= '0;
            r_bit_cnt   <= '0;
            r_tx        <= STOP_BIT;
            r_state     <= STOP;
          end else begin
            r_presc_cnt <= r_presc_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_presc_cnt <= '0;
            if (r_bit_cnt == LAST_STOP) begin
              r_bit_cnt <= '0;
              r_tx      <= STOP_BIT;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_bit_cnt <= w_bit_next;
            end
          end else begin
            r_presc_cnt <= r_presc_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_presc_cnt <= '0;
          r_bit_cnt   <= '0;
          r_tx        <= STOP_BIT;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of accepted bytes, cycle-exact frame checker.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

`ifdef UART_TX_STOP2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    int         p;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  uart_tx #(.OUT_data(8), .prescale_w(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic pt, input int p);
    exp_t e;
    e.data    = d;
    e.par_en  = pe;
    e.par_typ = pt;
    e.p       = (p == 0) ? 1 : p;
    sb.push_back(e);
  endtask

  // Pulses Data_Valid for one edge; returns at the negedge of the first start-bit cycle.
  task automatic start_tx(input logic [7:0] d, input logic pe, input logic pt, input int p, input bit push);
    @(negedge CLK);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = 6'(p);
    Data_Valid = 1'b1;
    if (push) push_exp(d, pe, pt, p);
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  // Called at the negedge of the first start-bit cycle; returns at the negedge of the idle cycle.
  task automatic check_frame(input string name, input int chg_cyc, input logic [7:0] chg_data,
                             input logic chg_dv, input int chg_p, input logic chg_pt,
                             output int busy_cnt, output logic [15:0] bits);
    exp_t        e;
    int          nb, len, bad_tx, first_bad;
    logic [15:0] exp_bits;
    logic        exp_par;
    busy_cnt = 0;
    bits     = '1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard: no expected frame queued", name);
      return;
    end
    e        = sb.pop_front();
    exp_par  = (^e.data) ^ e.par_typ;
    nb       = 1 + 8 + (e.par_en ? 1 : 0) + S;
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = e.data[i];
    if (e.par_en) exp_bits[9] = exp_par;
    len       = nb * e.p;
    bad_tx    = 0;
    first_bad = -1;
    for (int c = 0; c < len; c++) begin
      if (c == chg_cyc) begin
        P_DATA     = chg_data;
        Data_Valid = chg_dv;
        Prescale   = 6'(chg_p);
        PAR_TYP    = chg_pt;
      end
      if (Busy === 1'b1) busy_cnt++;
      if (TX_OUT !== exp_bits[c / e.p]) begin
        bad_tx++;
        if (first_bad < 0) first_bad = c;
      end
      if ((c % e.p) == (e.p / 2)) bits[c / e.p] = TX_OUT;
      @(negedge CLK);
    end
    checks++;
    if (bad_tx !== 0) begin
      failures++;
      $display("FAIL %s tx_timing: %0d wrong cycles (first at cycle %0d), required 0", name, bad_tx, first_bad);
    end
    checks++;
    if (busy_cnt !== len) begin
      failures++;
      $display("FAIL %s busy_len: got %0d busy cycles, required %0d", name, busy_cnt, len);
    end
    checks++;
    if (Busy !== 1'b0 || TX_OUT !== 1'b1) begin
      failures++;
      $display("FAIL %s idle_after: Busy=%b TX_OUT=%b, required Busy=0 TX_OUT=1", name, Busy, TX_OUT);
    end
    checks++;
    if (bits[8:1] !== e.data) begin
      failures++;
      $display("FAIL %s rx_data: decoded %h, required %h", name, bits[8:1], e.data);
    end
    if (e.par_en) begin
      checks++;
      if (bits[9] !== exp_par) begin
        failures++;
        $display("FAIL %s rx_parity: decoded %b, required %b", name, bits[9], exp_par);
      end
    end
    checks++;
    if (bits[nb-1] !== 1'b1) begin
      failures++;
      $display("FAIL %s rx_stop: decoded %b, required 1", name, bits[nb-1]);
    end
  endtask

  task automatic test_reset();
    RST        = 1'b1;
    Data_Valid = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;
    repeat (3) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0", TX_OUT, Busy);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_a5();
    int          bc;
    logic [15:0] bits;
    start_tx(8'hA5, 1'b1, 1'b0, 8, 1'b1);
    check_frame("a5", 30, 8'h00, 1'b0, 3, 1'b1, bc, bits);
    checks++;
    if (bits[10:0] !== 11'h54A) begin
      failures++;
      $display("FAIL a5 bit_sequence: got %b, required %b (LSB first on line)", bits[10:0], 11'h54A);
    end
    checks++;
    if (bc !== ((S == 2) ? 96 : 88)) begin
      failures++;
      $display("FAIL a5 busy_cycles: got %0d, required %0d", bc, (S == 2) ? 96 : 88);
    end
  endtask

  task automatic test_parity();
    int          bc;
    logic [15:0] bits;
    start_tx(8'h01, 1'b1, 1'b1, 4, 1'b1);
    check_frame("par_odd", -1, 8'h00, 1'b0, 4, 1'b1, bc, bits);
    checks++;
    if (bits[9] !== 1'b0) begin
      failures++;
      $display("FAIL par_odd parity_bit: got %b, required 0", bits[9]);
    end
    start_tx(8'h01, 1'b1, 1'b0, 4, 1'b1);
    check_frame("par_even", -1, 8'h00, 1'b0, 4, 1'b0, bc, bits);
    checks++;
    if (bits[9] !== 1'b1) begin
      failures++;
      $display("FAIL par_even parity_bit: got %b, required 1", bits[9]);
    end
  endtask

  task automatic test_no_parity();
    int          bc;
    logic [15:0] bits;
    start_tx(8'hFF, 1'b0, 1'b0, 16, 1'b1);
    check_frame("nopar", -1, 8'h00, 1'b0, 16, 1'b0, bc, bits);
    checks++;
    if (bc !== ((S == 2) ? 176 : 160)) begin
      failures++;
      $display("FAIL nopar busy_cycles: got %0d, required %0d", bc, (S == 2) ? 176 : 160);
    end
  endtask

  task automatic test_prescale_zero();
    int          bc;
    logic [15:0] bits;
    start_tx(8'h96, 1'b1, 1'b1, 0, 1'b1);
    check_frame("presc0", -1, 8'h00, 1'b0, 0, 1'b1, bc, bits);
  endtask

  task automatic test_back_to_back();
    int          bc;
    logic [15:0] bits;
    @(negedge CLK);
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;
    Data_Valid = 1'b1;
    push_exp(8'h3C, 1'b0, 1'b0, 8);
    push_exp(8'hC3, 1'b0, 1'b0, 8);
    @(negedge CLK);
    check_frame("b2b_first", 20, 8'hC3, 1'b1, 8, 1'b0, bc, bits);
    @(negedge CLK);
    check_frame("b2b_second", 20, 8'h5A, 1'b0, 13, 1'b1, bc, bits);
    repeat (3) @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || TX_OUT !== 1'b1) begin
      failures++;
      $display("FAIL b2b no_third_frame: Busy=%b TX_OUT=%b, required Busy=0 TX_OUT=1", Busy, TX_OUT);
    end
  endtask

  task automatic test_reset_mid();
    int          bc;
    logic [15:0] bits;
    int          bad;
    start_tx(8'h55, 1'b1, 1'b0, 4, 1'b0);
    repeat (17) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid abort: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0", TX_OUT, Busy);
    end
    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rst_mid stays_idle: %0d non-idle cycles, required 0", bad);
    end
    start_tx(8'hE7, 1'b1, 1'b0, 4, 1'b1);
    check_frame("rst_mid_clean", -1, 8'h00, 1'b0, 4, 1'b0, bc, bits);
  endtask

  task automatic test_loopback();
    int          bc;
    logic [15:0] bits;
    logic [7:0]  d;
    for (int pe = 0; pe < 2; pe++) begin
      for (int pt = 0; pt < 2; pt++) begin
        for (int r = 0; r < 3; r++) begin
          d = 8'($urandom_range(0, 255));
          start_tx(d, pe[0], pt[0], 8, 1'b1);
          check_frame("loopback", -1, 8'h00, 1'b0, 8, pt[0], bc, bits);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_parity();
    test_no_parity();
    test_prescale_zero();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d frames left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
